sm_bus_arbiter: RTL
===================

Name: sm_bus_arbiter

Overview:
Two-master arbiter for the single data bus into sm_matrix (memory, GPIO, PWM, ALS). Master 0 is the CPU data port and master 1 is a debug/DMA port.
It grants one master per cycle using round-robin with an optional bounded lock. It muxes the granted master onto the bus and returns a single-cycle ack.
It sits between sm_cpu/debug logic and sm_matrix in sm_top, on the divided clk domain.

Parameters:
MAX_HOLD, 4, max consecutive locked grants to one master while the other is requesting (1..15)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system (divided) clock
rst  in  1  synchronous active-high reset
m0Req  in  1  master 0 transfer request, held until m0Ack
m0Lock  in  1  master 0 asks to keep grant after current transfer
m0Addr  in  AW  master 0 address
m0Write  in  1  master 0 write enable
m0WData  in  DW  master 0 write data
m0RData  out  DW  master 0 read data, valid when m0Ack
m0Ack  out  1  master 0 transfer complete
m1Req, m1Lock, m1Addr, m1Write, m1WData, m1RData, m1Ack: same as master 0
bAddr  out  AW  bus address to sm_matrix
bWrite  out  1  bus write strobe
bWData  out  DW  bus write data
bRData  in  DW  bus read data (combinational from sm_matrix)
owner  out  2  current grant: 0 none, 1 = m0, 2 = m1 (debug visibility)

Behaviour:
- Grant register g, encoded NONE/G0/G1. Last-served pointer lastM (1 bit). Hold counter holdCnt (4 bit).
- Reset (rst=1 at posedge): g=NONE, lastM=1 (so m0 wins the first tie), holdCnt=0.
- Outputs while g=NONE: bAddr=0, bWrite=0, bWData=0, both acks 0.
- Owner cycle (g=Gx):
  - bAddr/bWrite/bWData = mx fields; mxAck=1; mxRData=bRData.
  - The non-owner's ack=0 and its rdata=0.
  - The write commits in sm_matrix at the end of this cycle.
- Latency: request sampled at edge E is acked in the cycle after E. Minimum 1 cycle from req to ack.
- Back-to-back transfers have no bubble. A master keeping req high after ack starts a new transfer.
- Next-grant rule, evaluated every cycle on the current req/lock:
  - No req: g'=NONE, holdCnt'=0.
  - Owner x has reqx & lockx, AND (other idle OR holdCnt < MAX_HOLD-1): g'=Gx, holdCnt'=holdCnt+1, saturating at 15.
  - Otherwise, only one requests: grant it.
  - Otherwise, both request: grant the master != lastM.
  - On any change of owner, holdCnt'=0.
- lastM updates to x on every cycle with g=Gx.
- Lock is ignored when the other master is idle for the purpose of starvation. With no contender, hold continues unbounded.
- Req dropped before ack: the grant is lost next cycle and no ack is issued. The masters must not do this; the arbiter does not flag it.
- Req and lock both asserted by a master not currently owner: treated as a plain req.
- rst asserted mid-transfer: the next cycle has g=NONE and no ack. A write in the reset cycle is still presented to the bus (sm_matrix uses its own reset).
- owner output = g, registered.

Decomposition:
- Grant encodings (SM_ARB_NONE=2'd0, SM_ARB_M0=2'd1, SM_ARB_M1=2'd2) and the default SM_ARB_MAX_HOLD go in sm_config.vh.
- One sub-module: sm_arb_rr_pick. It is purely combinational and maps (req[1:0], lock[1:0], g, lastM, holdCnt) to (gNext, holdNext).
- Registers and the bus mux stay in sm_bus_arbiter. Registers are built with sm_register-style flops extended for synchronous clear.

Test Plan:
1. Reset then m0Req=1, m0Addr=0x10, m0Write=0, bRData=0x1234 -> the cycle after the req edge: owner=1, m0Ack=1, m0RData=0x1234, bWrite=0; m1Ack=0 throughout.
2. Both req from reset, no lock, held 4 cycles -> owners 1,2,1,2 on consecutive cycles; acks alternate; no idle cycle between.
3. m1 write (addr 0x7F00, data 0xA5) alone -> bAddr=0x7F00, bWrite=1, bWData=0xA5 for exactly one cycle per ack; bWrite=0 when owner=0.
4. m0Req+m0Lock held, m1Req held, MAX_HOLD=4 -> owner=1 for 4 consecutive cycles, then owner=2 for one cycle, then back to 1.
5. m0Req+m0Lock, m1 idle, 20 cycles -> owner=1 all 20 cycles; holdCnt saturates at 15 with no glitch.
6. rst pulsed during owner=2 with both requesting -> owner=0 and acks=0 the cycle after; the first grant after reset goes to m0 (owner=1).

Source files
------------

// File: rtl/sm_bus_arbiter_pkg.sv
// Shared definitions for the two-master sm_matrix bus arbiter.
// Grant encodings double as the debug-visible owner value.
package sm_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      SM_ARB_NONE = 2'd0,
      SM_ARB_M0   = 2'd1,
      SM_ARB_M1   = 2'd2
   } arbGrant_t;

   localparam int SM_ARB_MAX_HOLD = 4;

endpackage

// File: rtl/sm_arb_rr_pick.sv
// Next-grant selection: round-robin between two masters with a
// lock that is bounded only while the other master is waiting.
module sm_arb_rr_pick
   import sm_bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = SM_ARB_MAX_HOLD
) (
   input  logic [1:0] req,
   input  logic [1:0] lock,
   input  logic [1:0] g,
   input  logic       lastM,
   input  logic [3:0] holdCnt,
   output logic [1:0] gNext,
   output logic [3:0] holdNext
);

   localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

   logic underLim;
   logic keep0;
   logic keep1;

   assign underLim = holdCnt < HOLD_LIM;
   assign keep0 = (g == SM_ARB_M0) & req[0] & lock[0]
                & (~req[1] | underLim);
   assign keep1 = (g == SM_ARB_M1) & req[1] & lock[1]
                & (~req[0] | underLim);

   always_comb begin
      gNext    = SM_ARB_NONE;
      holdNext = '0;
      if (keep0 | keep1) begin
         gNext    = keep0 ? SM_ARB_M0 : SM_ARB_M1;
         holdNext = (holdCnt == 4'hF) ? 4'hF : holdCnt + 4'd1;
      end else begin
         unique case (req)
            2'b01:   gNext = SM_ARB_M0;
            2'b10:   gNext = SM_ARB_M1;
            2'b11:   gNext = lastM ? SM_ARB_M0 : SM_ARB_M1;
            default: gNext = SM_ARB_NONE;
         endcase
      end
   end

endmodule

// File: rtl/sm_bus_arbiter.sv
// Two-master arbiter onto the sm_matrix data bus; grant state is
// registered and the bus/ack mux decodes straight from it.
module sm_bus_arbiter
   import sm_bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = SM_ARB_MAX_HOLD,
   parameter int AW       = 32,
   parameter int DW       = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0Req,
   input  logic          m0Lock,
   input  logic [AW-1:0] m0Addr,
   input  logic          m0Write,
   input  logic [DW-1:0] m0WData,
   output logic [DW-1:0] m0RData,
   output logic          m0Ack,
   input  logic          m1Req,
   input  logic          m1Lock,
   input  logic [AW-1:0] m1Addr,
   input  logic          m1Write,
   input  logic [DW-1:0] m1WData,
   output logic [DW-1:0] m1RData,
   output logic          m1Ack,
   output logic [AW-1:0] bAddr,
   output logic          bWrite,
   output logic [DW-1:0] bWData,
   input  logic [DW-1:0] bRData,
   output logic [1:0]    owner
);

   logic [1:0] g;
   logic [1:0] gNext;
   logic       lastM;
   logic       lastEff;
   logic [3:0] holdCnt;
   logic [3:0] holdNext;

   // The master served this cycle already counts as last served.
   assign lastEff = (g == SM_ARB_M0) ? 1'b0 :
                    (g == SM_ARB_M1) ? 1'b1 : lastM;

   sm_arb_rr_pick #(
      .MAX_HOLD(MAX_HOLD)
   ) uPick (
      .req     ({m1Req, m0Req}),
      .lock    ({m1Lock, m0Lock}),
      .g       (g),
      .lastM   (lastEff),
      .holdCnt (holdCnt),
      .gNext   (gNext),
      .holdNext(holdNext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         g       <= SM_ARB_NONE;
         lastM   <= 1'b1;
         holdCnt <= '0;
      end else begin
         g       <= gNext;
         lastM   <= lastEff;
         holdCnt <= holdNext;
      end
   end

   always_comb begin
      bAddr   = '0;
      bWrite  = 1'b0;
      bWData  = '0;
      m0Ack   = 1'b0;
      m1Ack   = 1'b0;
      m0RData = '0;
      m1RData = '0;
      unique case (g)
         SM_ARB_M0: begin
            bAddr   = m0Addr;
            bWrite  = m0Write;
            bWData  = m0WData;
            m0Ack   = 1'b1;
            m0RData = bRData;
         end
         SM_ARB_M1: begin
            bAddr   = m1Addr;
            bWrite  = m1Write;
            bWData  = m1WData;
            m1Ack   = 1'b1;
            m1RData = bRData;
         end
         default: ;
      endcase
   end

   assign owner = g;

endmodule
